// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, runs the memory
// handshakes with an optional ack timeout, and keeps cycle/retire counters.
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             dec_reg_we,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_halt,
    input  logic             br_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_load;
    logic              is_store;
    logic              timed_out;
    logic              active;

    // A word flagged as both load and store is treated as a load.
    assign is_load   = dec_is_load;
    assign is_store  = dec_is_store & ~dec_is_load;
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
    assign active    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC)
                    || (state_q == S_MEM) || (state_q == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt    <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (active) cycle_cnt <= cycle_cnt + CNT_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack)       state_q  <= S_DECODE;
                    else if (timed_out) state_q  <= S_FAULT;
                    else                wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                S_DECODE: begin
                    if (dec_is_halt) begin
                        state_q     <= S_HALT;
                        instret_cnt <= instret_cnt + CNT_W'(1);
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state_q  <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_load) begin
                            state_q <= S_WB;
                        end else begin
                            state_q     <= S_FETCH;
                            wait_cnt    <= '0;
                            instret_cnt <= instret_cnt + CNT_W'(1);
                        end
                    end else if (timed_out) begin
                        state_q <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state_q     <= S_FETCH;
                    wait_cnt    <= '0;
                    instret_cnt <= instret_cnt + CNT_W'(1);
                end
                default: state_q <= state_q;
            endcase
        end
    end

    // Strobes are decoded from the current state so they drop with an async reset.
    assign imem_req = (state_q == S_FETCH);
    assign ir_we    = imem_req & imem_ack;
    assign dmem_req = (state_q == S_MEM);
    assign dmem_we  = dmem_req & is_store;
    assign pc_we    = (state_q == S_WB) | (dmem_req & dmem_ack & is_store);
    assign pc_sel   = (state_q == S_WB) & br_taken;
    assign rf_we    = (state_q == S_WB) & dec_reg_we;
    assign halted   = (state_q == S_HALT);
    assign fault    = (state_q == S_FAULT);
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected output vectors are queued by the
// driver and compared by a negedge monitor; counters and async reset checked directly.
module tb_mc_ctrl;

    localparam int W = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        dec_reg_we = 1'b0;
    logic        dec_is_load = 1'b0;
    logic        dec_is_store = 1'b0;
    logic        dec_is_halt = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, halted, fault;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    logic [W-1:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int n_vec = 0;

    mc_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_halt(dec_is_halt), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .halted(halted), .fault(fault), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    // Vector layout: state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, halted, fault
    function automatic logic [W-1:0] ev(input logic [2:0] s, input logic [8:0] f);
        return {s, f};
    endfunction

    function automatic logic [W-1:0] act_vec();
        return {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, halted, fault};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            e = exp_q.pop_front();
            a = act_vec();
            n_chk++;
            if (a !== e) begin
                n_err++;
                $display("FAIL trace[%0d]: got %b want %b", n_vec, a, e);
            end
            n_vec++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_dec(input logic rw, input logic ld, input logic st, input logic hl, input logic bt);
        dec_reg_we = rw; dec_is_load = ld; dec_is_store = st; dec_is_halt = hl; br_taken = bt;
    endtask

    task automatic cyc(input logic s, input logic ia, input logic da, input logic [W-1:0] e);
        @(posedge clk);
        #1;
        start = s; imem_ack = ia; dmem_ack = da;
        exp_q.push_back(e);
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is visible before any edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk({name, "_state"}, 32'(state), 32'd0);
        chk({name, "_reqs"}, 32'({imem_req, dmem_req, pc_we, rf_we, ir_we}), 32'd0);
        chk({name, "_cnts"}, cycle_cnt | instret_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [8:0] F_NONE  = 9'b000000000;
    localparam logic [8:0] F_FETCH = 9'b100000000;
    localparam logic [8:0] F_FACK  = 9'b110000000;
    localparam logic [8:0] F_MEM   = 9'b001000000;
    localparam logic [8:0] F_STACK = 9'b001110000;
    localparam logic [8:0] F_WB_RW = 9'b000010100;
    localparam logic [8:0] F_WB_BR = 9'b000011100;
    localparam logic [8:0] F_WB    = 9'b000010000;
    localparam logic [8:0] F_HALT  = 9'b000000010;
    localparam logic [8:0] F_FAULT = 9'b000000001;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("por_state", 32'(state), 32'd0);
        chk("por_outs", 32'(act_vec()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op, zero-wait fetch
        set_dec(1, 0, 0, 0, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 0, ev(3'd5, F_WB_RW));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        chk("add_cycle_cnt", cycle_cnt, 32'd4);
        chk("add_instret", instret_cnt, 32'd1);

        // Load with ack on the last permitted cycle
        do_reset("rst1");
        set_dec(1, 1, 0, 0, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, ev(3'd4, F_MEM));
        cyc(0, 0, 1, ev(3'd4, F_MEM));
        cyc(0, 0, 0, ev(3'd5, F_WB_RW));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        chk("ld_cycle_cnt", cycle_cnt, 32'd8);
        chk("ld_instret", instret_cnt, 32'd1);

        // Store zero-wait, then a load+store word that must behave as a load
        do_reset("rst2");
        set_dec(0, 0, 1, 0, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 1, ev(3'd4, F_STACK));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        chk("st_cycle_cnt", cycle_cnt, 32'd4);
        chk("st_instret", instret_cnt, 32'd1);
        set_dec(1, 1, 1, 0, 0);
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 1, ev(3'd4, F_MEM));
        cyc(0, 0, 0, ev(3'd5, F_WB_RW));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        chk("ldst_instret", instret_cnt, 32'd2);

        // Taken branch then a not-taken non-writing op
        do_reset("rst3");
        set_dec(1, 0, 0, 0, 1);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 0, ev(3'd5, F_WB_BR));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        set_dec(0, 0, 0, 0, 0);
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 0, ev(3'd5, F_WB));
        cyc(0, 0, 0, ev(3'd1, F_FETCH));
        chk("br_instret", instret_cnt, 32'd2);
        chk("br_cycle_cnt", cycle_cnt, 32'd9);

        // Fetch timeout into FAULT; start and acks ignored afterwards
        do_reset("rst4");
        set_dec(0, 0, 0, 0, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, ev(3'd1, F_FETCH));
        cyc(0, 0, 0, ev(3'd7, F_FAULT));
        chk("to_cycle_cnt", cycle_cnt, 32'd4);
        cyc(1, 1, 1, ev(3'd7, F_FAULT));
        cyc(0, 0, 0, ev(3'd7, F_FAULT));
        chk("to_frozen_cycle", cycle_cnt, 32'd4);
        chk("to_frozen_instret", instret_cnt, 32'd0);

        // Halt from DECODE
        do_reset("rst5");
        set_dec(1, 0, 0, 1, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd6, F_HALT));
        cyc(1, 1, 1, ev(3'd6, F_HALT));
        chk("halt_instret", instret_cnt, 32'd1);
        chk("halt_cycle_cnt", cycle_cnt, 32'd2);

        // Reset while a data request is outstanding
        do_reset("rst6");
        set_dec(1, 1, 0, 0, 0);
        cyc(1, 0, 0, ev(3'd0, F_NONE));
        cyc(0, 1, 0, ev(3'd1, F_FACK));
        cyc(0, 0, 0, ev(3'd2, F_NONE));
        cyc(0, 0, 0, ev(3'd3, F_NONE));
        cyc(0, 0, 0, ev(3'd4, F_MEM));
        do_reset("midmem");
        cyc(0, 0, 0, ev(3'd0, F_NONE));

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
